// File: rtl/ibex_wb_pkg.sv
// Shared types and helpers for the writeback arbiter: source tags, load-buffer entry, counter width.
package ibex_wb_pkg;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_EX,
        WB_SRC_LSU
    } wb_src_e;

    localparam int WB_DATA_W = 32;
    localparam int WB_PERF_W = 32;

    typedef struct packed {
        logic [4:0]           addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // RV32E has 16 registers, so bit 4 of every register address is ignored.
    function automatic logic [4:0] wb_addr(input logic [4:0] a, input bit rv32e);
        return rv32e ? {1'b0, a[3:0]} : a;
    endfunction

endpackage

// File: rtl/ibex_wb_arbiter_if.sv
// Writeback arbiter bundle: EX and LSU write sources, load issue, hazard lookup, RF write port, counters.
interface ibex_wb_arbiter_if #(
    parameter int DataWidth = 32,
    parameter int NumWords  = 32
);
    logic                                ex_we_i;
    logic [4:0]                          ex_waddr_i;
    logic [DataWidth-1:0]                ex_wdata_i;
    logic                                lsu_rvalid_i;
    logic [4:0]                          lsu_waddr_i;
    logic [DataWidth-1:0]                lsu_rdata_i;
    logic                                lsu_rready_o;
    logic                                load_issue_i;
    logic [4:0]                          load_issue_addr_i;
    logic [4:0]                          raddr_a_i;
    logic [4:0]                          raddr_b_i;
    logic                                hazard_o;
    logic [NumWords-1:0]                 pending_o;
    logic                                rf_we_o;
    logic [4:0]                          rf_waddr_o;
    logic [DataWidth-1:0]                rf_wdata_o;
    logic [ibex_wb_pkg::WB_PERF_W-1:0]   perf_lsu_wr_o;
    logic [ibex_wb_pkg::WB_PERF_W-1:0]   perf_defer_o;

    modport master (
        output ex_we_i, ex_waddr_i, ex_wdata_i,
        output lsu_rvalid_i, lsu_waddr_i, lsu_rdata_i,
        output load_issue_i, load_issue_addr_i, raddr_a_i, raddr_b_i,
        input  lsu_rready_o, hazard_o, pending_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o, perf_lsu_wr_o, perf_defer_o
    );

    modport slave (
        input  ex_we_i, ex_waddr_i, ex_wdata_i,
        input  lsu_rvalid_i, lsu_waddr_i, lsu_rdata_i,
        input  load_issue_i, load_issue_addr_i, raddr_a_i, raddr_b_i,
        output lsu_rready_o, hazard_o, pending_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o, perf_lsu_wr_o, perf_defer_o
    );

endinterface

// File: rtl/ibex_wb_load_fifo.sv
// Generic FIFO buffering load responses that lose writeback arbitration.
// Latency: pushed entry visible at pop_dat the cycle after push.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module ibex_wb_load_fifo #(
    parameter int  Depth   = 2,
    parameter type entry_t = ibex_wb_pkg::wb_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push,
    input  entry_t push_dat,
    input  logic   pop,
    output entry_t pop_dat,
    output logic   full,
    output logic   empty
);
    localparam int             AW      = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [AW:0]    FullCnt = Depth[AW:0];

    entry_t      mem [2**AW];
    logic [AW:0] wr_ptr, rd_ptr;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr - rd_ptr) == FullCnt);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/ibex_wb_arbiter.sv
// Writeback arbiter: EX results and LSU load data share one RF write port; tracks pending loads for hazards.
// Latency: 1 cycle from selection to rf_we_o/rf_waddr_o/rf_wdata_o; hazard_o is combinational.
// Backpressure: lsu_rready_o drops while the load FIFO is full; EX never stalls. IBEX_WB_PERF_COUNTERS_EN adds counters.
module ibex_wb_arbiter
    import ibex_wb_pkg::*;
#(
    parameter bit RV32E         = 1'b0,
    parameter int DataWidth     = 32,
    parameter int LoadFifoDepth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    ibex_wb_arbiter_if.slave bus
);
    localparam int NumWords = RV32E ? 16 : 32;

    typedef struct packed {
        logic [4:0]           addr;
        logic [DataWidth-1:0] data;
    } entry_t;

    function automatic logic [NumWords-1:0] onehot(input logic [4:0] a);
        return {{(NumWords-1){1'b0}}, 1'b1} << a;
    endfunction

    logic [4:0]           ex_addr, lsu_addr, iss_addr, ra_addr, rb_addr;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop, lsu_rdy;
    logic                 ex_win, lsu_live;
    entry_t               head, lsu_ent;
    logic                 sel_we;
    logic [4:0]           sel_addr;
    logic [DataWidth-1:0] sel_data;
    wb_src_e              sel_src;
    logic                 rf_we_q;
    logic [4:0]           rf_waddr_q;
    logic [DataWidth-1:0] rf_wdata_q;
    wb_src_e              src_q;
    logic [NumWords-1:0]  pending_q, set_vec, clr_vec;

    assign ex_addr  = wb_addr(bus.ex_waddr_i, RV32E);
    assign lsu_addr = wb_addr(bus.lsu_waddr_i, RV32E);
    assign iss_addr = wb_addr(bus.load_issue_addr_i, RV32E);
    assign ra_addr  = wb_addr(bus.raddr_a_i, RV32E);
    assign rb_addr  = wb_addr(bus.raddr_b_i, RV32E);

    // Ready is sampled before this cycle's pop, so a full FIFO never sees push and pop together.
    assign lsu_rdy   = rst_ni & ~fifo_full;
    assign ex_win    = bus.ex_we_i && (ex_addr != 5'd0);
    assign lsu_live  = bus.lsu_rvalid_i && lsu_rdy && (lsu_addr != 5'd0);
    assign fifo_pop  = !ex_win && !fifo_empty;
    assign fifo_push = lsu_live && (ex_win || !fifo_empty);
    assign lsu_ent   = '{addr: lsu_addr, data: bus.lsu_rdata_i};

    ibex_wb_load_fifo #(
        .Depth   (LoadFifoDepth),
        .entry_t (entry_t)
    ) u_load_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (fifo_push),
        .push_dat (lsu_ent),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        sel_src  = WB_SRC_NONE;
        if (ex_win) begin
            sel_we   = 1'b1;
            sel_addr = ex_addr;
            sel_data = bus.ex_wdata_i;
            sel_src  = WB_SRC_EX;
        end else if (!fifo_empty) begin
            sel_we   = 1'b1;
            sel_addr = head.addr;
            sel_data = head.data;
            sel_src  = WB_SRC_LSU;
        end else if (lsu_live) begin
            sel_we   = 1'b1;
            sel_addr = lsu_addr;
            sel_data = bus.lsu_rdata_i;
            sel_src  = WB_SRC_LSU;
        end
    end

    // A load retires on the edge the RF captures its data; a same-cycle reissue keeps the bit set.
    assign set_vec = (bus.load_issue_i && iss_addr != 5'd0) ? onehot(iss_addr) : '0;
    assign clr_vec = (rf_we_q && src_q == WB_SRC_LSU) ? onehot(rf_waddr_q) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            src_q      <= WB_SRC_NONE;
            pending_q  <= '0;
        end else begin
            rf_we_q    <= sel_we;
            rf_waddr_q <= sel_addr;
            rf_wdata_q <= sel_data;
            src_q      <= sel_src;
            pending_q  <= (pending_q & ~clr_vec) | set_vec;
        end
    end

    assign bus.lsu_rready_o = lsu_rdy;
    assign bus.hazard_o     = |(pending_q & (onehot(ra_addr) | onehot(rb_addr)));
    assign bus.pending_o    = pending_q;
    assign bus.rf_we_o      = rf_we_q;
    assign bus.rf_waddr_o   = rf_waddr_q;
    assign bus.rf_wdata_o   = rf_wdata_q;

`ifdef IBEX_WB_PERF_COUNTERS_EN
    logic [WB_PERF_W-1:0] perf_lsu_wr_q, perf_defer_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_lsu_wr_q <= '0;
            perf_defer_q  <= '0;
        end else begin
            if (rf_we_q && src_q == WB_SRC_LSU) perf_lsu_wr_q <= perf_lsu_wr_q + 1'b1;
            if (ex_win && !fifo_empty)          perf_defer_q  <= perf_defer_q + 1'b1;
        end
    end

    assign bus.perf_lsu_wr_o = perf_lsu_wr_q;
    assign bus.perf_defer_o  = perf_defer_q;
`else
    assign bus.perf_lsu_wr_o = '0;
    assign bus.perf_defer_o  = '0;
`endif

    logic ex_hits_pend, iss_hits_pend, rsp_not_pend;
    assign ex_hits_pend  = ex_win && (|(pending_q & onehot(ex_addr)));
    assign iss_hits_pend = |(set_vec & pending_q & ~clr_vec);
    assign rsp_not_pend  = lsu_live && !(|(pending_q & onehot(lsu_addr)));

    a_ex_to_pending:  assert property (@(posedge clk_i) disable iff (!rst_ni) !ex_hits_pend);
    a_issue_pending:  assert property (@(posedge clk_i) disable iff (!rst_ni) !iss_hits_pend);
    a_rsp_unpending:  assert property (@(posedge clk_i) disable iff (!rst_ni) !rsp_not_pend);

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// Bench for ibex_wb_arbiter: directed scenarios then randomized legal traffic against a queue-based model.
module tb_ibex_wb_arbiter;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ibex_wb_arbiter_if #(.DataWidth(DW), .NumWords(32)) bus ();

    ibex_wb_arbiter #(
        .RV32E         (1'b0),
        .DataWidth     (DW),
        .LoadFifoDepth (DEPTH)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    // Reference state: buffered loads, pending set, what the RF port shows, counters.
    ent_t        mq[$];
    logic [4:0]  outst[$];
    logic [31:0] m_pend;
    logic        m_we, m_lsu, m_last_acc;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int unsigned m_lsu_wr, m_defer;
    logic [31:0] rf [32];
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) if (bus.rf_we_o) rf[bus.rf_waddr_o] <= bus.rf_wdata_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        bus.ex_we_i           = 1'b0;
        bus.ex_waddr_i        = '0;
        bus.ex_wdata_i        = '0;
        bus.lsu_rvalid_i      = 1'b0;
        bus.lsu_waddr_i       = '0;
        bus.lsu_rdata_i       = '0;
        bus.load_issue_i      = 1'b0;
        bus.load_issue_addr_i = '0;
        bus.raddr_a_i         = '0;
        bus.raddr_b_i         = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        outst.delete();
        m_pend     = '0;
        m_we       = 1'b0;
        m_lsu      = 1'b0;
        m_addr     = '0;
        m_data     = '0;
        m_lsu_wr   = 0;
        m_defer    = 0;
        m_last_acc = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied: check, advance the model, run one clock.
    task automatic step();
        int   sz;
        logic rdy, acc, exw, haz, iss;
        logic [4:0] ia;
        ent_t e;
        #1;
        sz  = mq.size();
        rdy = (sz < DEPTH);
        haz = (bus.raddr_a_i != 0 && m_pend[bus.raddr_a_i]) || (bus.raddr_b_i != 0 && m_pend[bus.raddr_b_i]);
        chk("rf_we", bus.rf_we_o, m_we);
        chk("rf_waddr", bus.rf_waddr_o, m_addr);
        chk("rf_wdata", bus.rf_wdata_o, m_data);
        chk("lsu_rready", bus.lsu_rready_o, rdy);
        chk("hazard", bus.hazard_o, haz);
        chk("pending", bus.pending_o, m_pend);
`ifdef IBEX_WB_PERF_COUNTERS_EN
        chk("perf_lsu_wr", bus.perf_lsu_wr_o, m_lsu_wr);
        chk("perf_defer", bus.perf_defer_o, m_defer);
`else
        chk("perf_lsu_wr", bus.perf_lsu_wr_o, 32'd0);
        chk("perf_defer", bus.perf_defer_o, 32'd0);
`endif
        acc = bus.lsu_rvalid_i && rdy;
        exw = bus.ex_we_i && bus.ex_waddr_i != 0;
        iss = bus.load_issue_i;
        ia  = bus.load_issue_addr_i;
        if (m_we && m_lsu) begin
            m_lsu_wr++;
            m_pend[m_addr] = 1'b0;
        end
        if (exw && sz > 0) m_defer++;
        if (iss && ia != 0) m_pend[ia] = 1'b1;
        m_we = 1'b0; m_lsu = 1'b0; m_addr = '0; m_data = '0;
        if (exw) begin
            m_we = 1'b1; m_addr = bus.ex_waddr_i; m_data = bus.ex_wdata_i;
        end else if (sz > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_lsu = 1'b1; m_addr = e.a; m_data = e.d;
        end else if (acc && bus.lsu_waddr_i != 0) begin
            m_we = 1'b1; m_lsu = 1'b1; m_addr = bus.lsu_waddr_i; m_data = bus.lsu_rdata_i;
        end
        if (acc && bus.lsu_waddr_i != 0 && (exw || sz > 0)) begin
            e.a = bus.lsu_waddr_i;
            e.d = bus.lsu_rdata_i;
            mq.push_back(e);
        end
        m_last_acc = acc;
        @(posedge clk);
        if (iss && ia != 0) outst.push_back(ia);
        @(negedge clk);
    endtask

    // Legal random traffic: responses only for issued loads, no EX write or reissue to a pending register.
    task automatic gen();
        logic [4:0] a;
        int k;
        if (!(bus.lsu_rvalid_i && !m_last_acc)) begin
            bus.lsu_rvalid_i = 1'b0;
            if (outst.size() > 0 && $urandom_range(0, 2) != 0) begin
                k = $urandom_range(0, outst.size() - 1);
                bus.lsu_waddr_i  = outst[k];
                outst.delete(k);
                bus.lsu_rvalid_i = 1'b1;
                bus.lsu_rdata_i  = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.lsu_rvalid_i = 1'b1;
                bus.lsu_waddr_i  = '0;
                bus.lsu_rdata_i  = $urandom;
            end
        end
        a = 5'($urandom_range(1, 31));
        bus.load_issue_addr_i = a;
        bus.load_issue_i      = !m_pend[a] && ($urandom_range(0, 1) == 1);
        a = 5'($urandom_range(0, 31));
        bus.ex_waddr_i = a;
        bus.ex_wdata_i = $urandom;
        bus.ex_we_i    = ($urandom_range(0, 1) == 1) &&
                         !(a != 0 && (m_pend[a] || (bus.load_issue_i && bus.load_issue_addr_i == a)));
        bus.raddr_a_i  = 5'($urandom_range(0, 31));
        bus.raddr_b_i  = 5'($urandom_range(0, 31));
    endtask

    initial begin
        int unsigned defer0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rf_we", bus.rf_we_o, 1'b0);
        chk("reset_pending", bus.pending_o, 32'd0);
        chk("reset_rready", bus.lsu_rready_o, 1'b0);
        chk("reset_wdata", bus.rf_wdata_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        step();

        // EX-only write
        bus.ex_we_i = 1'b1; bus.ex_waddr_i = 5'd5; bus.ex_wdata_i = 32'hDEADBEEF;
        step();
        idle(); #1;
        chk("ex_we", bus.rf_we_o, 1'b1);
        chk("ex_waddr", bus.rf_waddr_o, 32'd5);
        chk("ex_wdata", bus.rf_wdata_o, 32'hDEADBEEF);
        step();
        chk("x5_readback", rf[5], 32'hDEADBEEF);

        // Load bypass with hazard rise and fall
        idle(); bus.load_issue_i = 1'b1; bus.load_issue_addr_i = 5'd7;
        step();
        idle(); bus.raddr_a_i = 5'd7; #1;
        chk("haz_x7", bus.hazard_o, 1'b1);
        bus.lsu_rvalid_i = 1'b1; bus.lsu_waddr_i = 5'd7; bus.lsu_rdata_i = 32'h1234;
        step();
        idle(); bus.raddr_a_i = 5'd7; #1;
        chk("byp_we", bus.rf_we_o, 1'b1);
        chk("byp_waddr", bus.rf_waddr_o, 32'd7);
        chk("byp_wdata", bus.rf_wdata_o, 32'h1234);
        chk("byp_haz_hold", bus.hazard_o, 1'b1);
        step();
        idle(); bus.raddr_a_i = 5'd7; #1;
        chk("byp_haz_drop", bus.hazard_o, 1'b0);
        step();

        // Conflict: EX holds the port while x8 and x9 loads arrive
        idle(); bus.load_issue_i = 1'b1; bus.load_issue_addr_i = 5'd8; step();
        idle(); bus.load_issue_i = 1'b1; bus.load_issue_addr_i = 5'd9; step();
        idle(); step();
        defer0 = m_defer;
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.ex_we_i = 1'b1; bus.ex_waddr_i = 5'd3; bus.ex_wdata_i = $urandom;
            if (i < 2) begin
                bus.lsu_rvalid_i = 1'b1;
                bus.lsu_waddr_i  = (i == 0) ? 5'd8 : 5'd9;
                bus.lsu_rdata_i  = 32'h8800 + i;
            end else begin
                #1;
                chk("conf_rready_full", bus.lsu_rready_o, 1'b0);
            end
            step();
        end
        idle(); #1;
`ifdef IBEX_WB_PERF_COUNTERS_EN
        // x8 enters the FIFO during the first EX cycle, so only the later two see it non-empty.
        chk("conf_defer", bus.perf_defer_o, defer0 + 2);
`else
        chk("conf_defer", bus.perf_defer_o, 32'd0);
`endif
        step();
        #1;
        chk("drain_1st_addr", bus.rf_waddr_o, 32'd8);
        chk("drain_1st_data", bus.rf_wdata_o, 32'h8800);
        step();
        #1;
        chk("drain_2nd_addr", bus.rf_waddr_o, 32'd9);
        step();
        step();

        // x0 handling
        idle(); bus.ex_we_i = 1'b1; bus.ex_waddr_i = 5'd0; bus.ex_wdata_i = $urandom;
        step();
        idle(); #1;
        chk("x0_ex_drop", bus.rf_we_o, 1'b0);
        bus.lsu_rvalid_i = 1'b1; bus.lsu_waddr_i = 5'd0; bus.lsu_rdata_i = $urandom;
        chk("x0_rready", bus.lsu_rready_o, 1'b1);
        step();
        idle(); #1;
        chk("x0_lsu_drop", bus.rf_we_o, 1'b0);
        step();
        #1;
        chk("x0_no_late_write", bus.rf_we_o, 1'b0);

        // Set/clear collision on x4
        idle(); bus.load_issue_i = 1'b1; bus.load_issue_addr_i = 5'd4; step();
        idle(); bus.lsu_rvalid_i = 1'b1; bus.lsu_waddr_i = 5'd4; bus.lsu_rdata_i = $urandom; step();
        idle(); bus.load_issue_i = 1'b1; bus.load_issue_addr_i = 5'd4; #1;
        chk("coll_retiring", bus.rf_we_o, 1'b1);
        step();
        idle(); #1;
        chk("coll_pend4", bus.pending_o[4], 1'b1);
        step();

        // Reset with a full FIFO and a write in flight
        idle(); bus.load_issue_i = 1'b1; bus.load_issue_addr_i = 5'd8; step();
        idle(); bus.load_issue_i = 1'b1; bus.load_issue_addr_i = 5'd9; step();
        for (int i = 0; i < 2; i++) begin
            idle();
            bus.ex_we_i = 1'b1; bus.ex_waddr_i = 5'd3; bus.ex_wdata_i = $urandom;
            bus.lsu_rvalid_i = 1'b1; bus.lsu_waddr_i = (i == 0) ? 5'd8 : 5'd9; bus.lsu_rdata_i = $urandom;
            step();
        end
        idle(); #1;
        chk("prerst_full", bus.lsu_rready_o, 1'b0);
        chk("prerst_we", bus.rf_we_o, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_pending", bus.pending_o, 32'd0);
        chk("midrst_we", bus.rf_we_o, 1'b0);
        chk("midrst_rready", bus.lsu_rready_o, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rready", bus.lsu_rready_o, 1'b1);
        repeat (4) step();

        // Randomized legal traffic
        for (int c = 0; c < 3000; c++) begin
            gen();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
